// File: rtl/div_pkg.sv
// Shared types and constants for the line-divider requester.
package div_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StHold  = 2'd3
  } div_state_e;

  localparam int unsigned DefNumW = 16;
  localparam int unsigned DefDenW = 12;

  // Quotient reported for a zero denominator at the default width.
  localparam logic [DefNumW-1:0] DivZeroQuo = '1;

endpackage

// File: rtl/div_issue_ctrl.sv
// Requester side of the multicycle divider handshake: accepts an operand pair,
// pulses div_start_o, waits for div_done_i (with timeout) and presents the result.
module div_issue_ctrl
  import div_pkg::*;
#(
  parameter int unsigned NUM_W   = DefNumW,
  parameter int unsigned DEN_W   = DefDenW,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [NUM_W-1:0] in_num_i,
  input  logic [DEN_W-1:0] in_den_i,
  output logic             div_start_o,
  output logic [NUM_W-1:0] div_num_o,
  output logic [DEN_W-1:0] div_den_o,
  input  logic             div_done_i,
  input  logic [NUM_W-1:0] div_quo_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [NUM_W-1:0] out_quo_o,
  output logic             out_err_o,
  output logic             busy_o
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(TIMEOUT - 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic [DEN_W-1:0] den_q, den_d;
  logic [NUM_W-1:0] quo_q, quo_d;
  logic             err_q, err_d;
  logic             start_q, start_d;

  // Next-state, operand latch, timeout counter and result capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    den_d   = den_q;
    quo_d   = quo_q;
    err_d   = err_q;
    start_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          num_d = in_num_i;
          den_d = in_den_i;
          if (in_den_i == '0) begin
            // Divider is never started for a zero denominator.
            quo_d   = '1;
            err_d   = 1'b1;
            state_d = StHold;
          end else begin
            start_d = 1'b1;
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (cnt_q != CntMax) begin
          cnt_d = cnt_q + 1'b1;
        end
        // A done coinciding with the timeout cycle still counts as success.
        if (div_done_i) begin
          quo_d   = div_quo_i;
          err_d   = 1'b0;
          state_d = StHold;
        end else if (cnt_q == CntMax) begin
          quo_d   = '0;
          err_d   = 1'b1;
          state_d = StHold;
        end
      end
      StHold: begin
        if (out_ready_i) begin
          state_d = StIdle;
        end
      end
    endcase
  end

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      num_q   <= '0;
      den_q   <= '0;
      quo_q   <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      den_q   <= den_d;
      quo_q   <= quo_d;
      err_q   <= err_d;
      start_q <= start_d;
    end
  end

  // Handshake flags decode directly from state.
  always_comb begin
    in_ready_o  = (state_q == StIdle);
    out_valid_o = (state_q == StHold);
    busy_o      = (state_q != StIdle);
  end

  assign div_start_o = start_q;
  assign div_num_o   = num_q;
  assign div_den_o   = den_q;
  assign out_quo_o   = quo_q;
  assign out_err_o   = err_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed self-checking bench for div_issue_ctrl; the bench plays the divider.
module tb_div_issue_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_num;
  logic [11:0] in_den;
  logic        div_start;
  logic [15:0] div_num;
  logic [11:0] div_den;
  logic        div_done;
  logic [15:0] div_quo;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_quo;
  logic        out_err;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;
  int start_cnt = 0;

  div_issue_ctrl #(
    .NUM_W  (16),
    .DEN_W  (12),
    .TIMEOUT(16),
    .CNT_W  (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_num_i   (in_num),
    .in_den_i   (in_den),
    .div_start_o(div_start),
    .div_num_o  (div_num),
    .div_den_o  (div_den),
    .div_done_i (div_done),
    .div_quo_i  (div_quo),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_quo_o  (out_quo),
    .out_err_o  (out_err),
    .busy_o     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; sample 1ns after the edge and count start pulses.
  task automatic tick();
    @(posedge clk);
    #1;
    if (div_start === 1'b1) start_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 0; in_num = '0; in_den = '0;
    div_done = 0; div_quo = '0; out_ready = 0;
    tick(); tick();
    n_cmp++; if ({in_ready, div_start, out_valid, out_err, busy} !== 5'b10000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 10000",
                         {in_ready, div_start, out_valid, out_err, busy}); end
    n_cmp++; if ({div_num, div_den, out_quo} !== 44'd0) begin
      n_fail++; $display("FAIL reset_data: got %h want 0", {div_num, div_den, out_quo}); end
    rst = 1'b0;
    tick();
    n_cmp++; if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: in_ready=%b busy=%b want 1 0", in_ready, busy); end
  endtask

  task automatic test_basic();
    start_cnt = 0;
    in_valid = 1; in_num = 16'd100; in_den = 12'd7;
    tick();
    in_valid = 0;
    n_cmp++; if (div_start !== 1'b1) begin
      n_fail++; $display("FAIL basic_start: got %b want 1", div_start); end
    n_cmp++; if (div_num !== 16'd100 || div_den !== 12'd7) begin
      n_fail++; $display("FAIL basic_operands: got %0d/%0d want 100/7", div_num, div_den); end
    for (int i = 1; i <= 9; i++) begin
      n_cmp++; if (in_ready !== 1'b0 || busy !== 1'b1) begin
        n_fail++; $display("FAIL basic_busy: cycle %0d in_ready=%b busy=%b want 0 1",
                           i, in_ready, busy); end
      tick();
    end
    // Nine cycles after the start pulse the divider answers.
    div_done = 1; div_quo = 16'd14;
    tick();
    div_done = 0; div_quo = '0;
    n_cmp++; if (out_valid !== 1'b1 || out_quo !== 16'd14 || out_err !== 1'b0) begin
      n_fail++; $display("FAIL basic_result: valid=%b quo=%0d err=%b want 1 14 0",
                         out_valid, out_quo, out_err); end
    n_cmp++; if (start_cnt !== 1) begin
      n_fail++; $display("FAIL basic_one_pulse: got %0d pulses want 1", start_cnt); end
    n_cmp++; if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL basic_ready_hold: got %b want 0", in_ready); end
    out_ready = 1;
    tick();
    out_ready = 0;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_release: in_ready=%b out_valid=%b want 1 0",
                         in_ready, out_valid); end
  endtask

  task automatic test_div_zero();
    start_cnt = 0;
    in_valid = 1; in_num = 16'd50; in_den = 12'd0;
    tick();
    in_valid = 0;
    n_cmp++; if (out_valid !== 1'b1 || out_quo !== 16'hFFFF || out_err !== 1'b1) begin
      n_fail++; $display("FAIL dz_result: valid=%b quo=%h err=%b want 1 ffff 1",
                         out_valid, out_quo, out_err); end
    n_cmp++; if (div_num !== 16'd50 || div_den !== 12'd0) begin
      n_fail++; $display("FAIL dz_operands: got %0d/%0d want 50/0", div_num, div_den); end
    tick(); tick();
    n_cmp++; if (start_cnt !== 0) begin
      n_fail++; $display("FAIL dz_no_start: got %0d pulses want 0", start_cnt); end
    out_ready = 1;
    tick();
    out_ready = 0;
    n_cmp++; if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL dz_release: got %b want 1", in_ready); end
  endtask

  task automatic test_timeout();
    start_cnt = 0;
    in_valid = 1; in_num = 16'd9; in_den = 12'd3;
    tick();
    in_valid = 0;
    n_cmp++; if (div_start !== 1'b1) begin
      n_fail++; $display("FAIL to_start: got %b want 1", div_start); end
    // Cycles 1..16 after the start pulse are still waiting.
    for (int i = 1; i <= 16; i++) begin
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL to_early: cycle %0d out_valid=%b want 0", i, out_valid); end
    end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_quo !== 16'd0 || out_err !== 1'b1) begin
      n_fail++; $display("FAIL to_result: valid=%b quo=%h err=%b want 1 0 1",
                         out_valid, out_quo, out_err); end
    div_done = 1; div_quo = 16'h1234;
    tick();
    div_done = 0; div_quo = '0;
    n_cmp++; if (out_valid !== 1'b1 || out_quo !== 16'd0 || out_err !== 1'b1) begin
      n_fail++; $display("FAIL to_late_done: valid=%b quo=%h err=%b want 1 0 1",
                         out_valid, out_quo, out_err); end
    out_ready = 1;
    tick();
    out_ready = 0;
    n_cmp++; if (in_ready !== 1'b1 || start_cnt !== 1) begin
      n_fail++; $display("FAIL to_release: in_ready=%b pulses=%0d want 1 1", in_ready, start_cnt); end
  endtask

  task automatic test_backpressure();
    in_valid = 1; in_num = 16'd30; in_den = 12'd5;
    tick();
    in_valid = 0;
    tick();
    div_done = 1; div_quo = 16'd6;
    tick();
    div_done = 0; div_quo = '0;
    in_valid = 1; in_num = 16'd77; in_den = 12'd1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (out_valid !== 1'b1 || out_quo !== 16'd6 || out_err !== 1'b0 ||
                   in_ready !== 1'b0 || div_num !== 16'd30) begin
        n_fail++; $display("FAIL bp_hold: cycle %0d valid=%b quo=%0d err=%b rdy=%b num=%0d",
                           i, out_valid, out_quo, out_err, in_ready, div_num); end
      tick();
    end
    in_valid = 0;
    out_ready = 1;
    tick();
    out_ready = 0;
    n_cmp++; if (in_ready !== 1'b1 || busy !== 1'b0 || div_num !== 16'd30) begin
      n_fail++; $display("FAIL bp_release: rdy=%b busy=%b num=%0d want 1 0 30",
                         in_ready, busy, div_num); end
  endtask

  task automatic test_stray_done();
    div_done = 1; div_quo = 16'd99;
    tick();
    div_done = 0; div_quo = '0;
    tick();
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 ||
                 out_quo !== 16'd6) begin
      n_fail++; $display("FAIL stray_ignored: valid=%b rdy=%b busy=%b quo=%0d want 0 1 0 6",
                         out_valid, in_ready, busy, out_quo); end
    in_valid = 1; in_num = 16'd200; in_den = 12'd10;
    tick();
    in_valid = 0;
    tick(); tick();
    div_done = 1; div_quo = 16'd20;
    tick();
    div_done = 0; div_quo = '0;
    n_cmp++; if (out_valid !== 1'b1 || out_quo !== 16'd20 || out_err !== 1'b0) begin
      n_fail++; $display("FAIL stray_next_op: valid=%b quo=%0d err=%b want 1 20 0",
                         out_valid, out_quo, out_err); end
    out_ready = 1;
    tick();
    out_ready = 0;
  endtask

  task automatic test_reset_mid_wait();
    in_valid = 1; in_num = 16'd500; in_den = 12'd4;
    tick();
    in_valid = 0;
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    n_cmp++; if ({in_ready, div_start, out_valid, out_err, busy} !== 5'b10000) begin
      n_fail++; $display("FAIL rstmid_flags: got %b want 10000",
                         {in_ready, div_start, out_valid, out_err, busy}); end
    n_cmp++; if ({div_num, div_den, out_quo} !== 44'd0) begin
      n_fail++; $display("FAIL rstmid_data: got %h want 0", {div_num, div_den, out_quo}); end
    tick();
    rst = 1'b0;
    tick();
    start_cnt = 0;
    in_valid = 1; in_num = 16'd64; in_den = 12'd8;
    tick();
    in_valid = 0;
    tick(); tick(); tick();
    div_done = 1; div_quo = 16'd8;
    tick();
    div_done = 0; div_quo = '0;
    n_cmp++; if (out_valid !== 1'b1 || out_quo !== 16'd8 || out_err !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_next_op: valid=%b quo=%0d err=%b want 1 8 0",
                         out_valid, out_quo, out_err); end
    n_cmp++; if (start_cnt !== 1) begin
      n_fail++; $display("FAIL rstmid_pulses: got %0d want 1", start_cnt); end
    out_ready = 1;
    tick();
    out_ready = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_timeout();
    test_backpressure();
    test_stray_done();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Backstop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish want finish");
    $fatal(1);
  end

endmodule
